// File: rtl/apb_rr_master_arbiter.sv
// ---------------------------------------------------------------------------
// apb_rr_master_arbiter
//
// Shares one APB master port between NREQ bridge-side requesters. A
// round-robin arbiter picks a requester. The transfer then runs through the
// APB SETUP and ACCESS phases. Wait states are supported through Pready, and
// a transfer that waits too long is aborted with an error. The peripheral
// select is decoded from the address using the bridge's three-slave map.
//
// Ports:
//   Hclk, Hreset     clock; synchronous active-high reset
//   req              per-requester request, held until the matching done
//   req_addr         packed addresses, requester i at [32*i+31:32*i]
//   req_write        per-requester direction (1 = write)
//   req_wdata        packed write data
//   gnt              one-hot, high while the requester owns APB (SETUP..ACCESS)
//   done             one-hot single-cycle completion pulse
//   err              valid with done: decode miss or timeout
//   rdata            read data, valid with done on reads
//   Pselx..Pwdata    APB master outputs
//   Prdata, Pready   APB slave responses
// ---------------------------------------------------------------------------
module apb_rr_master_arbiter #(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 16
) (
  input  logic                 Hclk,
  input  logic                 Hreset,
  input  logic [NREQ-1:0]      req,
  input  logic [32*NREQ-1:0]   req_addr,
  input  logic [NREQ-1:0]      req_write,
  input  logic [32*NREQ-1:0]   req_wdata,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic                 err,
  output logic [31:0]          rdata,
  output logic [2:0]           Pselx,
  output logic                 Penable,
  output logic                 Pwrite,
  output logic [31:0]          Paddr,
  output logic [31:0]          Pwdata,
  input  logic [31:0]          Prdata,
  input  logic                 Pready
);

  localparam int IW = (NREQ > 2) ? 2 : 1;
  localparam int CW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t            state_reg, state_next;
  logic [NREQ-1:0]   gnt_reg, gnt_next;
  logic [NREQ-1:0]   done_reg, done_next;
  logic              err_reg, err_next;
  logic [31:0]       rdata_reg, rdata_next;
  logic [2:0]        psel_reg, psel_next;
  logic              penable_reg, penable_next;
  logic              pwrite_reg, pwrite_next;
  logic [31:0]       paddr_reg, paddr_next;
  logic [31:0]       pwdata_reg, pwdata_next;
  logic [IW-1:0]     ptr_reg, ptr_next;
  logic [IW-1:0]     idx_reg, idx_next;
  logic [CW-1:0]     count_reg, count_next;

  // Unpacked views of the per-requester buses.
  logic [31:0] addr_arr  [NREQ];
  logic [31:0] wdata_arr [NREQ];

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign addr_arr[gi]  = req_addr[32*gi +: 32];
      assign wdata_arr[gi] = req_wdata[32*gi +: 32];
    end
  endgenerate

  // Three 64 MB windows starting at 0x8000_0000. A zero result means a miss.
  function automatic logic [2:0] decode(input logic [31:0] a);
    case (a[31:26])
      6'b100000: decode = 3'b001;
      6'b100001: decode = 3'b010;
      6'b100010: decode = 3'b100;
      default:   decode = 3'b000;
    endcase
  endfunction

  // Round-robin search. It starts at ptr_reg and wraps modulo NREQ.
  // A requester whose done is high this cycle is not eligible.
  logic [NREQ-1:0] eligible;
  logic            win_found;
  logic [IW-1:0]   win_idx;
  int              cand;

  always_comb begin
    eligible  = req & ~done_reg;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand = int'(ptr_reg) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!win_found && eligible[cand]) begin
        win_found = 1'b1;
        win_idx   = IW'(cand);
      end
    end
  end

  logic [2:0]      win_sel;
  logic [NREQ-1:0] win_onehot;
  logic [NREQ-1:0] cur_onehot;

  assign win_sel    = decode(addr_arr[win_idx]);
  assign win_onehot = NREQ'(1) << win_idx;
  assign cur_onehot = NREQ'(1) << idx_reg;

  always_comb begin
    state_next   = state_reg;
    gnt_next     = gnt_reg;
    done_next    = '0;       // done and err are single-cycle pulses
    err_next     = 1'b0;
    rdata_next   = rdata_reg;
    psel_next    = psel_reg;
    penable_next = penable_reg;
    pwrite_next  = pwrite_reg;
    paddr_next   = paddr_reg;
    pwdata_next  = pwdata_reg;
    ptr_next     = ptr_reg;
    idx_next     = idx_reg;
    count_next   = count_reg;

    case (state_reg)
      IDLE: begin
        if (win_found) begin
          idx_next = win_idx;
          ptr_next = (int'(win_idx) + 1 == NREQ) ? '0 : IW'(int'(win_idx) + 1);
          if (win_sel != 3'b000) begin
            state_next  = SETUP;
            psel_next   = win_sel;
            paddr_next  = addr_arr[win_idx];
            pwrite_next = req_write[win_idx];
            pwdata_next = wdata_arr[win_idx];
            gnt_next    = win_onehot;
          end else begin
            // A decode miss completes with an error and starts no APB cycle.
            state_next = RESP;
            done_next  = win_onehot;
            err_next   = 1'b1;
          end
        end
      end

      SETUP: begin
        state_next   = ACCESS;
        penable_next = 1'b1;
        count_next   = '0;
      end

      ACCESS: begin
        count_next = count_reg + 1'b1;
        if (Pready || (count_reg == CW'(TIMEOUT - 1))) begin
          state_next   = RESP;
          done_next    = cur_onehot;
          err_next     = ~Pready;
          psel_next    = 3'b000;
          penable_next = 1'b0;
          gnt_next     = '0;
          count_next   = '0;
          if (Pready && !pwrite_reg) rdata_next = Prdata;
        end
      end

      RESP: begin
        state_next = IDLE;
        count_next = '0;
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      state_reg   <= IDLE;
      gnt_reg     <= '0;
      done_reg    <= '0;
      err_reg     <= 1'b0;
      rdata_reg   <= '0;
      psel_reg    <= 3'b000;
      penable_reg <= 1'b0;
      pwrite_reg  <= 1'b0;
      paddr_reg   <= '0;
      pwdata_reg  <= '0;
      ptr_reg     <= '0;
      idx_reg     <= '0;
      count_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      gnt_reg     <= gnt_next;
      done_reg    <= done_next;
      err_reg     <= err_next;
      rdata_reg   <= rdata_next;
      psel_reg    <= psel_next;
      penable_reg <= penable_next;
      pwrite_reg  <= pwrite_next;
      paddr_reg   <= paddr_next;
      pwdata_reg  <= pwdata_next;
      ptr_reg     <= ptr_next;
      idx_reg     <= idx_next;
      count_reg   <= count_next;
    end
  end

  assign gnt     = gnt_reg;
  assign done    = done_reg;
  assign err     = err_reg;
  assign rdata   = rdata_reg;
  assign Pselx   = psel_reg;
  assign Penable = penable_reg;
  assign Pwrite  = pwrite_reg;
  assign Paddr   = paddr_reg;
  assign Pwdata  = pwdata_reg;

endmodule

// File: tb/tb_apb_rr_master_arbiter.sv
// ---------------------------------------------------------------------------
// tb_apb_rr_master_arbiter
//
// Scoreboard bench for apb_rr_master_arbiter with NREQ=2 and TIMEOUT=16.
// Each expected completion (index, err, rdata) is queued when a request is
// raised. The monitor pops the queue on every done pulse. The APB slave model
// asserts Pready after wait_n ACCESS cycles and returns prdata_val.
// ---------------------------------------------------------------------------
module tb_apb_rr_master_arbiter;

  localparam int NREQ    = 2;
  localparam int TIMEOUT = 16;

  logic                Hclk = 1'b0;
  logic                Hreset;
  logic [NREQ-1:0]     req;
  logic [32*NREQ-1:0]  req_addr;
  logic [NREQ-1:0]     req_write;
  logic [32*NREQ-1:0]  req_wdata;
  logic [NREQ-1:0]     gnt;
  logic [NREQ-1:0]     done;
  logic                err;
  logic [31:0]         rdata;
  logic [2:0]          Pselx;
  logic                Penable;
  logic                Pwrite;
  logic [31:0]         Paddr;
  logic [31:0]         Pwdata;
  logic [31:0]         Prdata;
  logic                Pready;

  apb_rr_master_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .Hclk(Hclk), .Hreset(Hreset),
    .req(req), .req_addr(req_addr), .req_write(req_write), .req_wdata(req_wdata),
    .gnt(gnt), .done(done), .err(err), .rdata(rdata),
    .Pselx(Pselx), .Penable(Penable), .Pwrite(Pwrite), .Paddr(Paddr), .Pwdata(Pwdata),
    .Prdata(Prdata), .Pready(Pready)
  );

  always #5 Hclk = ~Hclk;

  typedef struct {
    int          idx;
    logic        err;
    logic        chk_rd;
    logic [31:0] rd;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          run = 0;
  int          last_run = 0;
  int          last_done_idx = -1;
  int          acc_cycles = 0;
  int          wait_n = 0;
  logic [31:0] prdata_val = 32'h0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // APB slave model: Pready rises in ACCESS cycle number wait_n (0-based).
  always @(posedge Hclk) begin
    if (Hreset || !Penable) acc_cycles <= 0;
    else                    acc_cycles <= acc_cycles + 1;
  end
  assign Pready = Penable && (acc_cycles == wait_n);
  assign Prdata = prdata_val;

  // Monitor: samples on the falling edge.
  always @(negedge Hclk) begin
    cyc++;
    if (Hreset) begin
      run = 0;
    end else begin
      if (Penable) begin
        run++;
        check("penable_without_psel", {31'b0, Pselx != 3'b000}, 32'd1);
      end
      if (done != '0) begin
        last_run = run;
        run = 0;
        for (int i = 0; i < NREQ; i++) if (done[i]) last_done_idx = i;
        check("done_gnt_overlap", 32'(gnt), 32'd0);
        if (sb.size() == 0) begin
          check("unexpected_done", 32'(done), 32'd0);
        end else begin
          mon_e = sb.pop_front();
          check("done_idx", 32'(done), 32'(1 << mon_e.idx));
          check("done_err", {31'b0, err}, {31'b0, mon_e.err});
          if (mon_e.chk_rd) check("rdata", rdata, mon_e.rd);
          $display("cycle %0d: done=%b err=%0d rdata=0x%08h access_cycles=%0d",
                   cyc, done, err, rdata, last_run);
        end
      end else begin
        check("err_without_done", {31'b0, err}, 32'd0);
      end
    end
  end

  task automatic tick();
    @(negedge Hclk);
    #1;
  endtask

  task automatic push_exp(input int idx, input logic e, input logic c, input logic [31:0] rd);
    exp_t x;
    x.idx = idx; x.err = e; x.chk_rd = c; x.rd = rd;
    sb.push_back(x);
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic w, input logic [31:0] d);
    req_addr[32*i +: 32]  = a;
    req_wdata[32*i +: 32] = d;
    req_write[i]          = w;
    req[i]                = 1'b1;
  endtask

  task automatic wait_done(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done != '0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("wait_done_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_penable(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (Penable) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("wait_penable_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_gnt"}, 32'(gnt), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_err"}, {31'b0, err}, 32'd0);
    check({tag, "_rdata"}, rdata, 32'd0);
    check({tag, "_psel"}, {29'b0, Pselx}, 32'd0);
    check({tag, "_penable"}, {31'b0, Penable}, 32'd0);
    check({tag, "_pwrite"}, {31'b0, Pwrite}, 32'd0);
    check({tag, "_paddr"}, Paddr, 32'd0);
    check({tag, "_pwdata"}, Pwdata, 32'd0);
  endtask

  task automatic do_reset();
    Hreset = 1'b1;
    tick();
    tick();
    Hreset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int prev_cyc;

  initial begin
    Hreset    = 1'b1;
    req       = '0;
    req_addr  = '0;
    req_write = '0;
    req_wdata = '0;

    // Reset state.
    tick();
    tick();
    tick();
    check_outputs_zero("reset");
    Hreset = 1'b0;

    // 1: single zero-wait write from requester 0.
    wait_n = 0;
    push_exp(0, 1'b0, 1'b1, 32'h0);       // a write leaves rdata at its reset value
    set_req(0, 32'h8000_0010, 1'b1, 32'hA5A5_0001);
    tick();                                // cycle 1: SETUP
    check("t1_setup_psel", {29'b0, Pselx}, 32'd1);
    check("t1_setup_penable", {31'b0, Penable}, 32'd0);
    check("t1_setup_gnt", 32'(gnt), 32'd1);
    check("t1_setup_paddr", Paddr, 32'h8000_0010);
    tick();                                // cycle 2: ACCESS
    check("t1_access_penable", {31'b0, Penable}, 32'd1);
    check("t1_access_psel", {29'b0, Pselx}, 32'd1);
    check("t1_access_pwrite", {31'b0, Pwrite}, 32'd1);
    check("t1_access_pwdata", Pwdata, 32'hA5A5_0001);
    tick();                                // cycle 3: RESP
    check("t1_done", 32'(done), 32'd1);
    req[0] = 1'b0;
    tick();
    check("t1_done_cleared", 32'(done), 32'd0);
    check("t1_psel_cleared", {29'b0, Pselx}, 32'd0);

    // 2: both requesters held from reset; grants alternate every 4 cycles.
    do_reset();
    prdata_val = 32'h1234_5678;
    push_exp(0, 1'b0, 1'b1, 32'h0);
    push_exp(1, 1'b0, 1'b1, 32'h1234_5678);
    push_exp(0, 1'b0, 1'b1, 32'h1234_5678);
    push_exp(1, 1'b0, 1'b1, 32'h1234_5678);
    set_req(0, 32'h8000_0100, 1'b1, 32'h0000_0011);
    set_req(1, 32'h8400_0200, 1'b0, 32'h0);
    prev_cyc = 0;
    for (int n = 0; n < 4; n++) begin
      wait_done(12);
      check("t2_rr_order", 32'(last_done_idx), 32'(n % 2));
      if (n > 0) check("t2_period", 32'(cyc - prev_cyc), 32'd4);
      prev_cyc = cyc;
    end
    req = '0;
    tick();

    // 3: read from slave 2 with three wait states.
    wait_n = 3;
    prdata_val = 32'hDEAD_BEEF;
    push_exp(1, 1'b0, 1'b1, 32'hDEAD_BEEF);
    set_req(1, 32'h8800_0004, 1'b0, 32'h0);
    wait_penable(6);
    for (int k = 0; k < 4; k++) begin
      check("t3_psel_held", {29'b0, Pselx}, 32'd4);
      check("t3_penable_held", {31'b0, Penable}, 32'd1);
      check("t3_paddr_held", Paddr, 32'h8800_0004);
      tick();
    end
    check("t3_done_after_ready", 32'(done), 32'd2);
    req[1] = 1'b0;
    tick();

    // 4: decode miss goes straight to RESP with err and no APB activity.
    push_exp(0, 1'b1, 1'b1, 32'hDEAD_BEEF);
    set_req(0, 32'h9000_0000, 1'b0, 32'h0);
    begin
      int k;
      for (k = 0; k < 6; k++) begin
        tick();
        check("t4_no_psel", {29'b0, Pselx}, 32'd0);
        check("t4_no_penable", {31'b0, Penable}, 32'd0);
        if (done != '0) break;
      end
      check("t4_miss_latency", 32'(k), 32'd0);
      check("t4_done", 32'(done), 32'd1);
    end
    req[0] = 1'b0;
    tick();

    // 5: timeout with requester 1, then requester 0 is served normally.
    wait_n = 1000;
    push_exp(1, 1'b1, 1'b1, 32'hDEAD_BEEF);
    push_exp(0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    set_req(1, 32'h8400_0000, 1'b0, 32'h0);
    set_req(0, 32'h8000_0020, 1'b1, 32'h5555_AAAA);
    wait_done(TIMEOUT + 8);
    check("t5_timeout_idx", 32'(last_done_idx), 32'd1);
    check("t5_access_cycles", 32'(last_run), 32'(TIMEOUT));
    req[1] = 1'b0;
    wait_n = 0;
    wait_done(12);
    check("t5_next_idx", 32'(last_done_idx), 32'd0);
    req[0] = 1'b0;
    tick();

    // 6: reset during ACCESS aborts without done; afterwards requester 0 wins.
    wait_n = 1000;
    set_req(1, 32'h8400_0040, 1'b0, 32'h0);
    wait_penable(6);
    tick();
    Hreset = 1'b1;
    tick();
    check_outputs_zero("t6_reset");
    Hreset = 1'b0;
    wait_n = 0;
    prdata_val = 32'hCAFE_0001;
    push_exp(0, 1'b0, 1'b1, 32'h0);
    push_exp(1, 1'b0, 1'b1, 32'hCAFE_0001);
    set_req(0, 32'h8800_0100, 1'b1, 32'h0BAD_F00D);
    wait_done(12);
    check("t6_first_after_reset", 32'(last_done_idx), 32'd0);
    req[0] = 1'b0;
    wait_done(12);
    check("t6_second_after_reset", 32'(last_done_idx), 32'd1);
    req[1] = 1'b0;
    tick();
    tick();

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
